// File: rtl/cpu_run_ctrl.sv
// Run/debug sequencer for the sccomp CPU: free run, N-step, breakpoint, watchdog and register dump.
// Optional registered commit trace is built when RUN_CTRL_TRACE_EN is defined.
module cpu_run_ctrl #(
  parameter int unsigned CYCLE_LIMIT = 1000,
  parameter int unsigned NREGS       = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_arg,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  output logic        cpu_en,
  output logic        halted,
  output logic [2:0]  halt_cause,
  output logic [31:0] retired,
  output logic        cmd_err,
  output logic [4:0]  reg_sel,
  input  logic [31:0] reg_data,
  output logic        dump_valid,
  output logic [4:0]  dump_idx,
  output logic [31:0] dump_data,
  output logic        trace_valid,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_instr
);

  typedef enum logic [1:0] {StHalted, StRun, StStep, StDump} state_e;

  localparam logic [1:0] OpRun  = 2'd0;
  localparam logic [1:0] OpStep = 2'd1;
  localparam logic [1:0] OpHalt = 2'd2;
  localparam logic [1:0] OpDump = 2'd3;

  localparam logic [2:0] CauseNone  = 3'd0;
  localparam logic [2:0] CauseHost  = 3'd1;
  localparam logic [2:0] CauseStep  = 3'd2;
  localparam logic [2:0] CauseBp    = 3'd3;
  localparam logic [2:0] CauseLimit = 3'd4;
  localparam logic [2:0] CauseZero  = 3'd5;

  localparam logic [31:0] CycleLimit = 32'(CYCLE_LIMIT);
  localparam logic [4:0]  LastReg    = 5'(NREGS - 1);

  state_e      state_q, state_d;
  logic [31:0] run_cnt_q, run_cnt_d;
  logic [31:0] step_cnt_q, step_cnt_d;
  logic        first_q, first_d;
  logic [31:0] retired_q, retired_d;
  logic [2:0]  cause_q, cause_d;
  logic [4:0]  reg_sel_q, reg_sel_d;
  logic        dump_valid_q, dump_valid_d;
  logic [4:0]  dump_idx_q, dump_idx_d;
  logic [31:0] dump_data_q, dump_data_d;
  logic        cmd_err_q, cmd_err_d;

  logic active, stop_zi, stop_bp, stop_wd, cmd_fire;

  assign active   = (state_q == StRun) || (state_q == StStep);
  assign stop_zi  = (instr == 32'd0);
  // first_q masks the breakpoint on the first cycle after resume so we can leave it.
  assign stop_bp  = bp_en && (pc == bp_addr) && !first_q;
  assign stop_wd  = (CYCLE_LIMIT != 0) && (state_q == StRun) && (run_cnt_q == CycleLimit);
  assign cpu_en   = active && !stop_zi && !stop_bp && !stop_wd && !rst;
  assign cmd_ready = (state_q != StDump);
  assign cmd_fire  = cmd_valid && cmd_ready;

  always_comb begin
    state_d      = state_q;
    run_cnt_d    = run_cnt_q;
    step_cnt_d   = step_cnt_q;
    first_d      = first_q;
    retired_d    = retired_q;
    cause_d      = cause_q;
    reg_sel_d    = reg_sel_q;
    dump_valid_d = 1'b0;
    dump_idx_d   = dump_idx_q;
    dump_data_d  = dump_data_q;
    cmd_err_d    = 1'b0;

    unique case (state_q)
      StHalted: begin
        if (cmd_fire) begin
          unique case (cmd_op)
            OpRun: begin
              state_d   = StRun;
              run_cnt_d = 32'd0;
              first_d   = 1'b1;
            end
            OpStep: begin
              state_d    = StStep;
              step_cnt_d = (cmd_arg == 32'd0) ? 32'd1 : cmd_arg;
              first_d    = 1'b1;
            end
            OpHalt: cause_d = CauseHost;
            OpDump: begin
              state_d   = StDump;
              reg_sel_d = 5'd0;
            end
          endcase
        end
      end

      StRun, StStep: begin
        if (cpu_en) begin
          retired_d = retired_q + 32'd1;
          first_d   = 1'b0;
          if (state_q == StRun) run_cnt_d = run_cnt_q + 32'd1;
          else                  step_cnt_d = step_cnt_q - 32'd1;
        end
        if (cmd_fire) begin
          if (cmd_op == OpHalt) begin
            state_d = StHalted;
            cause_d = CauseHost;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        // Internal stops are assigned last so they override a simultaneous host HALT.
        if (stop_zi) begin
          state_d = StHalted;
          cause_d = CauseZero;
        end else if (stop_bp) begin
          state_d = StHalted;
          cause_d = CauseBp;
        end else if (stop_wd) begin
          state_d = StHalted;
          cause_d = CauseLimit;
        end else if (state_q == StStep && step_cnt_q == 32'd1) begin
          state_d = StHalted;
          cause_d = CauseStep;
        end
      end

      StDump: begin
        dump_valid_d = 1'b1;
        dump_idx_d   = reg_sel_q;
        dump_data_d  = reg_data;
        if (reg_sel_q == LastReg) begin
          state_d   = StHalted;
          reg_sel_d = 5'd0;
        end else begin
          reg_sel_d = reg_sel_q + 5'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StHalted;
      run_cnt_q    <= 32'd0;
      step_cnt_q   <= 32'd0;
      first_q      <= 1'b0;
      retired_q    <= 32'd0;
      cause_q      <= CauseNone;
      reg_sel_q    <= 5'd0;
      dump_valid_q <= 1'b0;
      dump_idx_q   <= 5'd0;
      dump_data_q  <= 32'd0;
      cmd_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_cnt_q    <= run_cnt_d;
      step_cnt_q   <= step_cnt_d;
      first_q      <= first_d;
      retired_q    <= retired_d;
      cause_q      <= cause_d;
      reg_sel_q    <= reg_sel_d;
      dump_valid_q <= dump_valid_d;
      dump_idx_q   <= dump_idx_d;
      dump_data_q  <= dump_data_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

  assign halted     = (state_q == StHalted);
  assign halt_cause = cause_q;
  assign retired    = retired_q;
  assign cmd_err    = cmd_err_q;
  assign reg_sel    = reg_sel_q;
  assign dump_valid = dump_valid_q;
  assign dump_idx   = dump_idx_q;
  assign dump_data  = dump_data_q;

`ifdef RUN_CTRL_TRACE_EN
  logic        trace_valid_q;
  logic [31:0] trace_pc_q, trace_instr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      trace_valid_q <= 1'b0;
      trace_pc_q    <= 32'd0;
      trace_instr_q <= 32'd0;
    end else begin
      trace_valid_q <= cpu_en;
      if (cpu_en) begin
        trace_pc_q    <= pc;
        trace_instr_q <= instr;
      end
    end
  end

  assign trace_valid = trace_valid_q;
  assign trace_pc    = trace_pc_q;
  assign trace_instr = trace_instr_q;
`else
  assign trace_valid = 1'b0;
  assign trace_pc    = 32'd0;
  assign trace_instr = 32'd0;
`endif

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Run/debug controller that sequences the single-cycle CPU inside sccomp.
- Gates CPU progress with a per-cycle instruction enable.
- Supports free run, N-instruction step, PC breakpoint and run-cycle watchdog.
- Walks the register-file debug read port (reg_sel/reg_data) to stream a full register dump. It replaces ad-hoc simulation stop/dump logic with synthesizable control.

Parameters:
- CYCLE_LIMIT, 1000, maximum enabled cycles per RUN command; 0 disables the watchdog.
- NREGS, 32, number of registers walked by DUMP (index 0..NREGS-1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready at a rising edge.
- cmd_op  in  2  0=RUN, 1=STEP, 2=HALT, 3=DUMP.
- cmd_arg  in  32  STEP count; 0 is treated as 1; ignored for other ops.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  32  breakpoint PC.
- pc  in  32  current CPU PC (PC of the instruction that executes if cpu_en=1).
- instr  in  32  instruction at pc.
- cpu_en  out  1  CPU commits the current instruction at this edge; combinational.
- halted  out  1  controller is in HALTED.
- halt_cause  out  3  0=none, 1=host, 2=step done, 3=breakpoint, 4=cycle limit, 5=zero instruction.
- retired  out  32  instructions committed since reset; wraps modulo 2^32.
- cmd_err  out  1  one-cycle pulse: command dropped.
- reg_sel  out  5  register-file debug read index.
- reg_data  in  32  combinational register read of reg_sel.
- dump_valid  out  1  dump beat valid.
- dump_idx  out  5  register index of beat.
- dump_data  out  32  register value of beat.
- trace_valid  out  1  trace beat valid (see Optional Feature).
- trace_pc  out  32  trace PC.
- trace_instr  out  32  trace instruction.

Behaviour:
- States are HALTED, RUN, STEP and DUMP.
- Reset value: state HALTED, halted=1, halt_cause=0, retired=0, reg_sel=0, dump_valid=0, dump_idx=0, dump_data=0, cmd_err=0, trace_* = 0. cpu_en=0 in the reset cycle.
- Reset mid-RUN/STEP/DUMP aborts at that edge; no dump beat follows.
- cmd_ready is 1 in HALTED, RUN and STEP, and 0 in DUMP.
- HALTED:
  - RUN goes to RUN; the run counter is cleared and the first-cycle flag is set.
  - STEP goes to STEP; the step counter is loaded with max(cmd_arg,1).
  - DUMP goes to DUMP with reg_sel=0.
  - HALT: stay in HALTED, halt_cause=1.
- RUN/STEP:
  - HALT goes to HALTED at that edge with cause 1. cpu_en is still as computed in that cycle, so the instruction may commit.
  - RUN, STEP or DUMP is consumed, no state change, cmd_err=1 for one cycle.
- Stop conditions, evaluated combinationally in RUN/STEP:
  - ZI: instr==0.
  - BP: bp_en && pc==bp_addr && !first_cycle.
  - WD: CYCLE_LIMIT!=0 && run_cnt==CYCLE_LIMIT (RUN only).
- Stop priority is ZI > BP > WD.
- cpu_en = (RUN||STEP) && !ZI && !BP && !WD.
- If any stop condition holds: go to HALTED with the matching cause; the instruction is not committed.
- Each cpu_en=1 cycle: retired+1, run_cnt+1 (RUN), step counter−1 (STEP), first_cycle cleared.
- STEP: when the step counter goes 1→0 with cpu_en=1, go to HALTED with cause 2 at that edge.
- An internal stop (ZI/BP/WD/step done) overrides a simultaneous host HALT cause.
- Breakpoint masking on resume: first_cycle also applies to STEP, so stepping off a breakpoint works.
- DUMP timing:
  - Cycle k (k=0..NREGS−1): reg_sel=k.
  - Cycle k+1: dump_valid=1, dump_idx=k, dump_data=reg_data sampled at cycle k.
  - After beat NREGS−1: go to HALTED, halt_cause unchanged, reg_sel=0.
  - Total NREGS+1 cycles from acceptance to halted=1.
  - cpu_en=0 throughout.
- halt_cause holds until the next stop.

Optional Feature:
- Macro: RUN_CTRL_TRACE_EN.
- Defined: for every cycle with cpu_en=1, the next cycle has trace_valid=1, trace_pc=pc and trace_instr=instr, all registered.
- Undefined: trace_valid, trace_pc and trace_instr are tied to 0 and no trace registers are built.

Test Plan:
- Reset, then STEP arg=3 with nonzero instrs → exactly 3 cpu_en cycles, halted=1, halt_cause=2, retired=3.
- bp_en=1, bp_addr=0x70, RUN → cpu_en=0 in the cycle pc==0x70, halt_cause=3. Then STEP arg=1 → commits the instruction at 0x70, halt_cause=2.
- CYCLE_LIMIT=1000, RUN with no breakpoint → 1000 cpu_en cycles, halt_cause=4. Issuing STEP during RUN → cmd_err pulse, run unaffected.
- RUN, instr=0x00000000 at cycle 5 → 5 commits, halt_cause=5. Same cycle also pc==bp_addr → cause still 5.
- DUMP with reg model rf[i]=i*0x11 → 32 beats, dump_idx 0..31, dump_data i*0x11, halted after 33 cycles, cmd_ready=0 during dump.
- Assert rst mid-RUN and at beat 10 of DUMP → next cycle halted=1, halt_cause=0, retired=0, dump_valid=0. With RUN_CTRL_TRACE_EN, trace beats match pc/instr one cycle late.
